// File: rtl/sump_cmd_decoder_pkg.sv
// sump_cmd_decoder_pkg
//   Shared definitions for the SUMP/OLS host command path: opcode values,
//   decoder state encodings and the short-opcode strobe decoder. Also used by
//   the metadata sender FSM and the core command handler.
package sump_cmd_decoder_pkg;

   localparam logic [7:0] OP_RESET = 8'h00;
   localparam logic [7:0] OP_RUN   = 8'h01;
   localparam logic [7:0] OP_ID    = 8'h02;
   localparam logic [7:0] OP_META  = 8'h04;
   localparam logic [7:0] OP_XON   = 8'h11;
   localparam logic [7:0] OP_XOFF  = 8'h13;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_LONG  = 1'b1;

   // Strobe vector order: {sw_reset, arm, query_id, query_metadata, xon, xoff}
   function automatic logic [5:0] decode_short(input logic [7:0] op);
      logic [5:0] stb;
      case (op)
         OP_RESET: stb = 6'b100000;
         OP_RUN:   stb = 6'b010000;
         OP_ID:    stb = 6'b001000;
         OP_META:  stb = 6'b000100;
         OP_XON:   stb = 6'b000010;
         OP_XOFF:  stb = 6'b000001;
         default:  stb = 6'b000000;
      endcase
      return stb;
   endfunction

endpackage

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder
//   Assembles UART bytes into SUMP short (1-byte, bit7=0) and long
//   (opcode with bit7=1 + 4 little-endian data bytes) commands and issues a
//   one-cycle execute strobe plus decoded strobes. A long command is aborted
//   with timeout_err if the gap between its bytes reaches TIMEOUT_CYCLES.
//
// Ports
//   clock, extReset      : clock and synchronous active-high reset
//   rx_valid, rx_data    : received byte strobe and value
//   execute              : one-cycle command strobe (opcode/command_data valid)
//   opcode, command_data : last completed command, held between commands
//   sw_reset .. xoff     : one-cycle decoded short-command strobes
//   timeout_err          : one-cycle strobe, long command aborted
module sump_cmd_decoder
   import sump_cmd_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TMR_W          = 17
) (
   input  logic        clock,
   input  logic        extReset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        execute,
   output logic [7:0]  opcode,
   output logic [31:0] command_data,
   output logic        sw_reset,
   output logic        arm,
   output logic        query_id,
   output logic        query_metadata,
   output logic        xon,
   output logic        xoff,
   output logic        timeout_err
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

   logic [0:0]       state_q,        state_d;
   logic [1:0]       cnt_q,          cnt_d;
   logic [TMR_W-1:0] tmr_q,          tmr_d;
   logic [7:0]       long_op_q,      long_op_d;
   logic [23:0]      shift_q,        shift_d;
   logic             execute_q,      execute_d;
   logic [7:0]       opcode_q,       opcode_d;
   logic [31:0]      command_data_q, command_data_d;
   logic [5:0]       strobes_q,      strobes_d;
   logic             timeout_err_q,  timeout_err_d;

   // Next-state and output decode for the byte assembler
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tmr_d          = tmr_q;
      long_op_d      = long_op_q;
      shift_d        = shift_q;
      execute_d      = 1'b0;
      opcode_d       = opcode_q;
      command_data_d = command_data_q;
      strobes_d      = 6'b000000;
      timeout_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               if (rx_data[7] == 1'b0) begin
                  execute_d      = 1'b1;
                  opcode_d       = rx_data;
                  command_data_d = 32'h0000_0000;
                  strobes_d      = decode_short(rx_data);
               end else begin
                  long_op_d = rx_data;
                  shift_d   = 24'h00_0000;
                  cnt_d     = 2'd0;
                  tmr_d     = '0;
                  state_d   = ST_LONG;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LONG: begin
            if (rx_valid) begin
               tmr_d = '0;
               case (cnt_q)
                  2'd0: shift_d[7:0]   = rx_data;
                  2'd1: shift_d[15:8]  = rx_data;
                  2'd2: shift_d[23:16] = rx_data;
                  default: begin
                     // Fourth byte goes straight to the output, completing the word
                     execute_d      = 1'b1;
                     opcode_d       = long_op_q;
                     command_data_d = {rx_data, shift_q};
                     state_d        = ST_IDLE;
                  end
               endcase
               cnt_d = cnt_q + 2'd1;
            end else begin
               if (tmr_q == TMR_LAST) begin
                  timeout_err_d = 1'b1;
                  tmr_d         = '0;
                  state_d       = ST_IDLE;
               end else if (tmr_q != TMR_MAX) begin
                  tmr_d = tmr_q + 1'b1;
               end else begin
                  tmr_d = tmr_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous reset dominates rx_valid
   always_ff @(posedge clock) begin
      if (extReset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 2'd0;
         tmr_q          <= '0;
         long_op_q      <= 8'h00;
         shift_q        <= 24'h00_0000;
         execute_q      <= 1'b0;
         opcode_q       <= 8'h00;
         command_data_q <= 32'h0000_0000;
         strobes_q      <= 6'b000000;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tmr_q          <= tmr_d;
         long_op_q      <= long_op_d;
         shift_q        <= shift_d;
         execute_q      <= execute_d;
         opcode_q       <= opcode_d;
         command_data_q <= command_data_d;
         strobes_q      <= strobes_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign execute        = execute_q;
   assign opcode         = opcode_q;
   assign command_data   = command_data_q;
   assign sw_reset       = strobes_q[5];
   assign arm            = strobes_q[4];
   assign query_id       = strobes_q[3];
   assign query_metadata = strobes_q[2];
   assign xon            = strobes_q[1];
   assign xoff           = strobes_q[0];
   assign timeout_err    = timeout_err_q;

endmodule
